dtw_axis_tx: RTL and testbench



---
 rtl/dtw_pkg.sv | 30 +++
 rtl/dtw_sync_fifo.sv | 59 +++++
 rtl/dtw_axis_tx.sv | 148 ++++++++++++++
 tb/tb_dtw_axis_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW accelerator stream blocks.
package dtw_pkg;

    localparam int DTW_AXIS_W     = 32;
    localparam int DTW_FIFO_DEPTH = 16;
    localparam int DTW_PKT_LEN_W  = 16;

    // Buffered result word at the default stream width: data plus end-of-run marker.
    typedef struct packed {
        logic                  last;
        logic [DTW_AXIS_W-1:0] data;
    } dtw_entry_t;

    // Output stage states.
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } dtw_tx_state_t;

    // Ceiling log2, used for pointer widths; returns 0 for values <= 1.
    function automatic int dtw_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dtw_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and show-ahead read data.
// Depth must be a power of two (>= 2); pointers carry one extra wrap bit.
module dtw_sync_fifo
    import dtw_pkg::*;
#(
    parameter int DEPTH = DTW_FIFO_DEPTH,
    parameter int WIDTH = DTW_AXIS_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [dtw_clog2(DEPTH):0]     count
);

    localparam int AW = dtw_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // Full/empty come from the registered count, so a write is judged before any same-cycle read.
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dtw_axis_tx.sv
// Result-side AXI4-Stream master: buffers core result words and emits them
// with TLAST every dtw_pkt_len beats or on a core-marked last word.
// Optional build macro DTW_TX_PKT_CNT_EN adds the dtw_tx_pkt_cnt packet counter.
//
// state   | meaning
// TX_IDLE | no beat presented, TVALID low
// TX_SEND | beat held in output registers, TVALID high until accepted
module dtw_axis_tx
    import dtw_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = DTW_AXIS_W,
    parameter int FIFO_DEPTH           = DTW_FIFO_DEPTH,
    parameter int PKT_LEN_W            = DTW_PKT_LEN_W
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic                                dtw_fifo_wren,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     dtw_fifo_din,
    input  logic                                dtw_fifo_last,
    output logic                                dtw_fifo_full,
    input  logic [PKT_LEN_W-1:0]                dtw_pkt_len,
    output logic                                dtw_tx_ovf,
    output logic                                dtw_tx_busy,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
`ifdef DTW_TX_PKT_CNT_EN
    ,
    output logic [31:0]                         dtw_tx_pkt_cnt
`endif
);

    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int AW = dtw_clog2(FIFO_DEPTH);

    dtw_tx_state_t     r_state;
    dtw_tx_state_t     w_state_next;
    logic [W-1:0]      r_tdata;
    logic              r_tlast;
    logic              r_ovf;
    logic [PKT_LEN_W-1:0] r_cnt;
    logic [PKT_LEN_W-1:0] r_len;
    logic [PKT_LEN_W-1:0] w_cnt_next;
    logic [PKT_LEN_W-1:0] w_len_in;
    logic [PKT_LEN_W-1:0] w_len_eff;
    logic              w_pop;
    logic              w_hs;
    logic              w_tlast_new;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [W:0]        w_fifo_rdata;

    dtw_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W + 1)
    ) u_fifo (
        .clk     (M_AXIS_ACLK),
        .rst_n   (M_AXIS_ARESETN),
        .wr_en   (dtw_fifo_wren),
        .wr_data ({dtw_fifo_last, dtw_fifo_din}),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rdata),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_hs          = (r_state == TX_SEND) && M_AXIS_TREADY;
    assign M_AXIS_TVALID = (r_state == TX_SEND);
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TLAST  = r_tlast;
    assign M_AXIS_TSTRB  = '1;
    assign dtw_fifo_full = w_full;
    assign dtw_tx_ovf    = r_ovf;
    assign dtw_tx_busy   = (w_count != '0) || M_AXIS_TVALID;

    // The popped word's position in its packet is the count after this cycle's handshake,
    // which lets back-to-back pops see the beat that is leaving right now.
    assign w_cnt_next  = w_hs ? (r_tlast ? '0 : r_cnt + PKT_LEN_W'(1)) : r_cnt;
    assign w_len_in    = (dtw_pkt_len == '0) ? PKT_LEN_W'(1) : dtw_pkt_len;
    assign w_len_eff   = (w_cnt_next == '0) ? w_len_in : r_len;
    assign w_tlast_new = w_fifo_rdata[W] || (w_cnt_next == w_len_eff - PKT_LEN_W'(1));

    // State register.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) r_state <= TX_IDLE;
        else                 r_state <= w_state_next;
    end

    // Next state and pop decision: refill on every accepted beat to keep 1 beat/cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (M_AXIS_TREADY) begin
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_next = TX_IDLE;
                end
            end
        endcase
    end

    // Output beat registers, beat counter and packet length latched at packet start.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_tdata <= '0;
            r_tlast <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_pop) begin
                r_tdata <= w_fifo_rdata[W-1:0];
                r_tlast <= w_tlast_new;
                r_len   <= w_len_eff;
            end
        end
    end

    // Sticky overflow flag: a write arrived while the buffer was full.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN)              r_ovf <= 1'b0;
        else if (dtw_fifo_wren && w_full) r_ovf <= 1'b1;
    end

`ifdef DTW_TX_PKT_CNT_EN
    logic [31:0] r_pkt_cnt;

    // Count completed packets; wraps naturally at 32 bits.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN)     r_pkt_cnt <= '0;
        else if (w_hs && r_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end

    assign dtw_tx_pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_dtw_axis_tx.sv
// Scoreboard bench for dtw_axis_tx: expected beats (data + TLAST) are derived
// from the packetisation rules when words are written; a negedge monitor
// pops and compares on each handshake and checks stall stability.
module tb_dtw_axis_tx;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wren = 1'b0;
    logic [DW-1:0] din = '0;
    logic          last = 1'b0;
    logic          full;
    logic [LW-1:0] pkt_len = 16'd1;
    logic          ovf;
    logic          busy;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tstrb;
    logic          tlast;
    logic          tready = 1'b0;
`ifdef DTW_TX_PKT_CNT_EN
    logic [31:0]   pkt_cnt;
`endif

    dtw_axis_tx #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .PKT_LEN_W            (LW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .dtw_fifo_wren  (wren),
        .dtw_fifo_din   (din),
        .dtw_fifo_last  (last),
        .dtw_fifo_full  (full),
        .dtw_pkt_len    (pkt_len),
        .dtw_tx_ovf     (ovf),
        .dtw_tx_busy    (busy),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready)
`ifdef DTW_TX_PKT_CNT_EN
        ,
        .dtw_tx_pkt_cnt (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DW:0] exp_q[$];
    int hs_cyc[$];
    int m_idx = 0;
    int m_len = 1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference packetiser: position within packet, length fixed at packet start.
    task automatic model_push(input logic [DW-1:0] d, input logic l);
        logic t;
        if (m_idx == 0) m_len = (pkt_len == 0) ? 1 : int'(pkt_len);
        t = l || (m_idx == m_len - 1);
        exp_q.push_back({t, d});
        m_idx = t ? 0 : m_idx + 1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic l, input bit acc);
        wren = 1'b1;
        din  = d;
        last = l;
        if (acc) model_push(d, l);
        @(posedge clk); #1;
        wren = 1'b0;
        last = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_drain: actual=timeout(%0d beats pending) required=drained", name, exp_q.size());
        end
    endtask

    // Monitor: scoreboard compare on handshake, and hold checks while stalled.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(tvalid === 1'b1 && tdata === held_d && tlast === held_l)) begin
                    failures++;
                    $display("FAIL stall_hold: actual v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                             tvalid, tdata, tlast, held_d, held_l);
                end
            end
            if (tvalid && tready) begin
                hs_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_extra: actual beat d=%0h l=%0b required none", tdata, tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        failures++;
                        $display("FAIL scoreboard_beat: actual l=%0b d=%0h required l=%0b d=%0h",
                                 tlast, tdata, e[DW], e[DW-1:0]);
                    end
                end
            end
            stall_prev = tvalid && !tready;
            held_d = tdata;
            held_l = tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        int sent;
        int guard;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tstrb", tstrb, 4'hF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Short packet with latency and back-to-back checks
        pkt_len = 16'd2;
        tready  = 1'b1;
        hs_cyc.delete();
        wr(32'h11, 1'b0, 1'b1);
        chk("lat_edge_k", tvalid, 0);
        wr(32'h22, 1'b0, 1'b1);
        chk("lat_edge_k1", tvalid, 1);
        wr(32'h33, 1'b1, 1'b1);
        drain("t1", 50);
        chk("t1_beats", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) chk("t1_no_bubble", hs_cyc[2] - hs_cyc[0], 2);

        // pkt_len=4, eight words streamed without bubbles
        pkt_len = 16'd4;
        hs_cyc.delete();
        for (int i = 1; i <= 8; i++) wr(32'h100 + i, 1'b0, 1'b1);
        drain("t2", 50);
        chk("t2_beats", hs_cyc.size(), 8);
        if (hs_cyc.size() == 8) chk("t2_no_bubble", hs_cyc[7] - hs_cyc[0], 7);

        // Early last, then counting restarts; pkt_len=0 behaves as 1
        pkt_len = 16'd16;
        for (int i = 1; i <= 5; i++) wr(32'h200 + i, (i == 5), 1'b1);
        drain("t3a", 50);
        pkt_len = 16'd2;
        for (int i = 1; i <= 2; i++) wr(32'h300 + i, 1'b0, 1'b1);
        drain("t3b", 50);
        pkt_len = 16'd0;
        for (int i = 1; i <= 3; i++) wr(32'h400 + i, 1'b0, 1'b1);
        drain("t3c", 50);
        chk("t3_ovf_clear", ovf, 0);

        // Overflow under stall: one word sits in the output stage, 16 in the buffer
        tready  = 1'b0;
        pkt_len = 16'd16;
        hs_cyc.delete();
        for (int i = 1; i <= DEPTH + 2; i++) begin
            wr(32'hA00 + i, 1'b0, (i <= DEPTH + 1));
            if (i == DEPTH)     chk("ovf_full_lo", full, 0);
            if (i == DEPTH + 1) begin
                chk("ovf_full_hi", full, 1);
                chk("ovf_not_yet", ovf, 0);
            end
            if (i == DEPTH + 2) chk("ovf_set", ovf, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_stall_data", tdata, 32'hA01);
        tready = 1'b1;
        drain("t4", 100);
        chk("ovf_beats_out", hs_cyc.size(), DEPTH + 1);
        chk("ovf_sticky", ovf, 1);

        // Random backpressure over 200 words
        pkt_len = LW'($urandom_range(1, 7));
        done  = 1'b0;
        sent  = 0;
        guard = 0;
        fork
            begin
                while (sent < 200 && guard < 20000) begin
                    guard++;
                    if (($urandom % 4) != 0 && !full) begin
                        wr($urandom, (($urandom % 8) == 0), 1'b1);
                        sent++;
                    end else begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tready = $urandom % 2;
                    @(posedge clk); #1;
                end
            end
        join
        chk("rand_all_sent", sent, 200);
        tready = 1'b1;
        drain("t5", 500);

        // Reset mid-packet with buffered data
        tready  = 1'b0;
        pkt_len = 16'd3;
        for (int i = 1; i <= 6; i++) wr(32'hB00 + i, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        m_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        tready = 1'b1;
`ifdef DTW_TX_PKT_CNT_EN
        chk("pkt_cnt_zero", pkt_cnt, 0);
`endif
        hs_cyc.delete();
        for (int i = 1; i <= 3; i++) wr(32'hC00 + i, 1'b0, 1'b1);
        drain("t6", 50);
        chk("post_rst_beats", hs_cyc.size(), 3);
`ifdef DTW_TX_PKT_CNT_EN
        chk("pkt_cnt_one", pkt_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
